// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake bundle for sync_fifo_param.
// master = the client side driving requests, slave = the FIFO itself.
interface sync_fifo_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] data_in;
   logic              write_en;
   logic              read_en;
   logic              flush;
   logic              err_clr;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   modport master (
      output data_in, write_en, read_en, flush, err_clr,
      input  data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  data_in, write_en, read_en, flush, err_clr,
      output data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush and
// sticky overflow/underflow bits.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through read
// data; left undefined, data_out is a register loaded on each accepted read.
module sync_fifo_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = 14,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic               clk1,
   input  logic               reset,
   sync_fifo_param_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              full_c;
   logic              empty_c;
   logic              wr_acc;
   logic              rd_acc;
   logic              ovf_set;
   logic              udf_set;
   logic              ovf_q;
   logic              udf_q;

   // Status from the registered count and request acceptance; flush blocks both sides
   always_comb begin
      full_c  = (count_q == CNT_W'(DEPTH));
      empty_c = (count_q == '0);
      wr_acc  = bus.write_en && !full_c  && !bus.flush;
      rd_acc  = bus.read_en  && !empty_c && !bus.flush;
      ovf_set = bus.write_en && full_c   && !bus.flush;
      udf_set = bus.read_en  && empty_c  && !bus.flush;
   end

   // Pointers and occupancy; flush empties the FIFO without touching storage
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
         count_q <= count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk1) begin
      if (wr_acc) mem[wr_ptr] <= bus.data_in;
   end

   // Sticky error bits; a new error in the clear cycle keeps the bit set
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (ovf_set)          ovf_q <= 1'b1;
         else if (bus.err_clr) ovf_q <= 1'b0;
         if (udf_set)          udf_q <= 1'b1;
         else if (bus.err_clr) udf_q <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word shown directly; read_en pops it
   assign bus.data_out = empty_c ? '0 : mem[rd_ptr];
`else
   logic [DATA_W-1:0] data_q;

   // Registered read data, updated only on an accepted read
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset)       data_q <= '0;
      else if (rd_acc) data_q <= mem[rd_ptr];
   end

   assign bus.data_out = data_q;
`endif

   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
   assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: self-checking bench for sync_fifo_param using a queue model.
module tb_sync_fifo_param;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned AF_LEVEL = 14;
   localparam int unsigned AE_LEVEL = 2;

   logic clk1 = 1'b0;
   logic reset = 1'b1;
   always #5 clk1 = ~clk1;

   sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   sync_fifo_param #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk1  (clk1),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of stored words plus error flags and read register
   logic [7:0] q[$];
   bit         ovf_m;
   bit         udf_m;
   logic [7:0] dout_m;

   function automatic logic [7:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
      return (q.size() != 0) ? q[0] : 8'h00;
`else
      return dout_m;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      dout_m = 8'h00;
   endtask

   task automatic idle();
      bus.data_in  = 8'h00;
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      bus.flush    = 1'b0;
      bus.err_clr  = 1'b0;
   endtask

   // Advance the model by one clock using current inputs, then step the DUT
   task automatic tick();
      bit was_full;
      bit was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (reset) begin
         model_reset();
      end else begin
         if (bus.write_en && was_full && !bus.flush) ovf_m = 1'b1;
         else if (bus.err_clr)                        ovf_m = 1'b0;
         if (bus.read_en && was_empty && !bus.flush)  udf_m = 1'b1;
         else if (bus.err_clr)                        udf_m = 1'b0;
         if (bus.flush) begin
            q.delete();
         end else begin
            if (bus.read_en && !was_empty) dout_m = q.pop_front();
            if (bus.write_en && !was_full) q.push_back(bus.data_in);
         end
      end
      @(posedge clk1);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic fill(input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         bus.write_en = 1'b1;
         bus.data_in  = base + 8'(k);
         tick();
      end
      bus.write_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.empty !== 1'b1)        begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
      n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got=%0b exp=1", bus.almost_empty); end
      n_checks++; if (bus.full !== 1'b0)         begin n_fail++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
      n_checks++; if (bus.almost_full !== 1'b0)  begin n_fail++; $display("FAIL reset_almost_full got=%0b exp=0", bus.almost_full); end
      n_checks++; if (bus.count !== 5'd0)        begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      n_checks++; if (bus.data_out !== 8'h00)    begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", bus.data_out); end
      n_checks++; if (bus.overflow !== 1'b0)     begin n_fail++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
      n_checks++; if (bus.underflow !== 1'b0)    begin n_fail++; $display("FAIL reset_underflow got=%0b exp=0", bus.underflow); end
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.write_en = 1'b1;
         bus.data_in  = 8'(i + 1);
         tick();
         n_checks++; if (bus.count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i + 1); end
         n_checks++; if (bus.full !== ((i + 1) == 16)) begin n_fail++; $display("FAIL fill_full at %0d got=%0b", i + 1, bus.full); end
         n_checks++; if (bus.almost_full !== ((i + 1) >= 14)) begin n_fail++; $display("FAIL fill_almost_full at %0d got=%0b", i + 1, bus.almost_full); end
      end
      bus.write_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         n_checks++; if (bus.data_out !== 8'(i + 1)) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", bus.data_out, 8'(i + 1)); end
         bus.read_en = 1'b1;
         tick();
`else
         bus.read_en = 1'b1;
         tick();
         n_checks++; if (bus.data_out !== 8'(i + 1)) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", bus.data_out, 8'(i + 1)); end
`endif
      end
      bus.read_en = 1'b0;
      n_checks++; if (bus.empty !== 1'b1)  begin n_fail++; $display("FAIL drain_empty got=%0b exp=1", bus.empty); end
      n_checks++; if (bus.count !== 5'd0)  begin n_fail++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
   endtask

   task automatic test_overflow();
      do_reset();
      fill(16, 8'h01);
      bus.write_en = 1'b1;
      bus.data_in  = 8'hFF;
      tick();
      bus.write_en = 1'b0;
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0b exp=1", bus.overflow); end
      n_checks++; if (bus.count !== 5'd16)   begin n_fail++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%0b exp=0", bus.overflow); end
      for (int i = 0; i < 16; i++) begin
         bus.read_en = 1'b1;
         tick();
         n_checks++; if (bus.data_out !== exp_dout()) begin n_fail++; $display("FAIL ovf_drain_data got=%h exp=%h", bus.data_out, exp_dout()); end
      end
      bus.read_en = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_no_extra_word empty=%0b exp=1", bus.empty); end
   endtask

   task automatic test_underflow();
      do_reset();
      bus.write_en = 1'b1;
      bus.read_en  = 1'b1;
      bus.data_in  = 8'hAA;
      tick();
      idle();
      n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set got=%0b exp=1", bus.underflow); end
      n_checks++; if (bus.count !== 5'd1)     begin n_fail++; $display("FAIL udf_count got=%0d exp=1", bus.count); end
`ifdef SYNC_FIFO_FWFT_EN
      n_checks++; if (bus.data_out !== 8'hAA) begin n_fail++; $display("FAIL udf_read_data got=%h exp=aa", bus.data_out); end
      bus.read_en = 1'b1;
      tick();
`else
      bus.read_en = 1'b1;
      tick();
      n_checks++; if (bus.data_out !== 8'hAA) begin n_fail++; $display("FAIL udf_read_data got=%h exp=aa", bus.data_out); end
`endif
      bus.read_en = 1'b0;
      n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty_after got=%0b exp=1", bus.empty); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fill(8, 8'h00);
      for (int i = 0; i < 40; i++) begin
         bus.write_en = 1'b1;
         bus.read_en  = 1'b1;
         bus.data_in  = 8'(8 + i);
         tick();
         n_checks++; if (bus.count !== 5'd8) begin n_fail++; $display("FAIL b2b_count cycle %0d got=%0d exp=8", i, bus.count); end
`ifdef SYNC_FIFO_FWFT_EN
         n_checks++; if (bus.data_out !== 8'(i + 1)) begin n_fail++; $display("FAIL b2b_data cycle %0d got=%h exp=%h", i, bus.data_out, 8'(i + 1)); end
`else
         n_checks++; if (bus.data_out !== 8'(i)) begin n_fail++; $display("FAIL b2b_data cycle %0d got=%h exp=%h", i, bus.data_out, 8'(i)); end
`endif
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      fill(5, 8'h30);
      bus.read_en = 1'b1;
      tick();
      bus.read_en  = 1'b0;
      bus.write_en = 1'b1;
      bus.data_in  = 8'h77;
      bus.flush    = 1'b1;
      tick();
      idle();
      n_checks++; if (bus.count !== 5'd0)         begin n_fail++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
      n_checks++; if (bus.empty !== 1'b1)         begin n_fail++; $display("FAIL flush_empty got=%0b exp=1", bus.empty); end
      n_checks++; if (bus.overflow !== 1'b0)      begin n_fail++; $display("FAIL flush_overflow got=%0b exp=0", bus.overflow); end
      n_checks++; if (bus.underflow !== 1'b0)     begin n_fail++; $display("FAIL flush_underflow got=%0b exp=0", bus.underflow); end
      n_checks++; if (bus.data_out !== exp_dout()) begin n_fail++; $display("FAIL flush_data_hold got=%h exp=%h", bus.data_out, exp_dout()); end
      bus.write_en = 1'b1;
      bus.data_in  = 8'h5A;
      tick();
      bus.write_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
`endif
      n_checks++; if (bus.data_out !== 8'h5A) begin n_fail++; $display("FAIL flush_then_write got=%h exp=5a", bus.data_out); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      fill(3, 8'h40);
      reset = 1'b1;
      #2;
      n_checks++; if (bus.count !== 5'd0)      begin n_fail++; $display("FAIL async_reset_count got=%0d exp=0", bus.count); end
      n_checks++; if (bus.empty !== 1'b1)      begin n_fail++; $display("FAIL async_reset_empty got=%0b exp=1", bus.empty); end
      n_checks++; if (bus.data_out !== 8'h00)  begin n_fail++; $display("FAIL async_reset_data got=%h exp=00", bus.data_out); end
      model_reset();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int wprob;
      int rprob;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         wprob = ((i / 100) % 2 == 0) ? 75 : 30;
         rprob = ((i / 100) % 2 == 0) ? 35 : 75;
         bus.write_en = ($urandom_range(0, 99) < wprob);
         bus.read_en  = ($urandom_range(0, 99) < rprob);
         bus.flush    = ($urandom_range(0, 39) == 0);
         bus.err_clr  = ($urandom_range(0, 15) == 0);
         bus.data_in  = 8'($urandom);
         tick();
         n_checks++; if (bus.count !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_count cycle %0d got=%0d exp=%0d", i, bus.count, q.size()); end
         n_checks++; if (bus.full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full cycle %0d got=%0b", i, bus.full); end
         n_checks++; if (bus.empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty cycle %0d got=%0b", i, bus.empty); end
         n_checks++; if (bus.almost_full !== (q.size() >= AF_LEVEL)) begin n_fail++; $display("FAIL rnd_almost_full cycle %0d got=%0b", i, bus.almost_full); end
         n_checks++; if (bus.almost_empty !== (q.size() <= AE_LEVEL)) begin n_fail++; $display("FAIL rnd_almost_empty cycle %0d got=%0b", i, bus.almost_empty); end
         n_checks++; if (bus.overflow !== ovf_m) begin n_fail++; $display("FAIL rnd_overflow cycle %0d got=%0b exp=%0b", i, bus.overflow, ovf_m); end
         n_checks++; if (bus.underflow !== udf_m) begin n_fail++; $display("FAIL rnd_underflow cycle %0d got=%0b exp=%0b", i, bus.underflow, udf_m); end
         n_checks++; if (bus.data_out !== exp_dout()) begin n_fail++; $display("FAIL rnd_data_out cycle %0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
      end
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_flush();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for buffering byte streams inside one clock domain, next generation of the team's FIFO family. Adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error bits. Sits between producer and consumer blocks that share `clk1`, where a dual-clock FIFO is unnecessary.

## Interface
- `DATA_W`, 8, data word width in bits (>=1)
- `DEPTH`, 16, number of entries; power of two, >=4
- `AF_LEVEL`, 14, `almost_full` asserts when count >= AF_LEVEL (1..DEPTH)
- `AE_LEVEL`, 2, `almost_empty` asserts when count <= AE_LEVEL (0..DEPTH-1)

- `clk1` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-high reset
- `data_in` in DATA_W — write data
- `write_en` in 1 — write request
- `read_en` in 1 — read request (pop)
- `flush` in 1 — synchronous empty-the-FIFO command
- `err_clr` in 1 — synchronous clear of sticky error bits
- `data_out` out DATA_W — read data
- `full` out 1 — count == DEPTH
- `empty` out 1 — count == 0
- `almost_full` out 1 — count >= AF_LEVEL
- `almost_empty` out 1 — count <= AE_LEVEL
- `count` out $clog2(DEPTH)+1 — current occupancy 0..DEPTH
- `overflow` out 1 — sticky: write attempted while full
- `underflow` out 1 — sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_W register array; write/read pointers of $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Write accepted iff `write_en && !full` (flags sampled before the edge); stores `data_in` at wr_ptr, wr_ptr+1.
- Read accepted iff `read_en && !empty`; rd_ptr+1.
- `count` next = count + wr_acc - rd_acc; both accepted in same cycle -> count unchanged, both pointers advance.
- Full + both requests: read accepted, write rejected, `overflow` sets. Empty + both: write accepted, read rejected, `underflow` sets.
- `overflow` sets on `write_en && full`; `underflow` on `read_en && empty`; both hold until `err_clr` or reset. Set in same cycle as `err_clr` -> set wins.
- `flush` priority over write/read: pointers and count -> 0, no write/read accepted that cycle, no error set; `data_out` holds; error bits unaffected.
- All flags derived combinationally from registered `count`; no extra flag latency.
- Reset: pointers 0, count 0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (unless AF_LEVEL... AF_LEVEL>=1 so 0), `overflow`=`underflow`=0, `data_out`=0. Reset mid-operation discards contents immediately.

## Timing
- Write-to-flag latency: 1 cycle (`empty` falls on the edge after first accepted write).
- Standard mode: `data_out` is registered, loaded with mem[rd_ptr] on the edge of an accepted read; valid 1 cycle after `read_en`; holds otherwise.
- Full throughput: one write and one read per cycle sustained.
- Write to an empty FIFO followed by read next cycle returns that word.

## Configuration
- Macro `SYNC_FIFO_FWFT_EN`.
- Defined: first-word-fall-through; `data_out` = mem[rd_ptr] combinationally whenever `!empty` (0 when empty), head word visible 1 cycle after its write; `read_en` acknowledges/pops the shown word.
- Undefined: standard registered-read mode described above.

## Test plan
- Reset then idle -> `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0, errors 0.
- Write 0x01..0x10 (16 words, DEPTH=16) then read 16 -> `full` at count 16, `almost_full` from count 14, data read back 0x01..0x10 in order, `empty` after last.
- Fill to 16, write 0xFF again -> rejected, `overflow`=1, count stays 16; `err_clr` -> `overflow`=0.
- Read while empty with simultaneous write 0xAA -> `underflow`=1, count 1, next read returns 0xAA.
- Hold count at 8, assert write and read together for 40 cycles with incrementing data -> count stays 8, output sequence in order across pointer wrap.
- Fill 5 words, pulse `flush` with `write_en`=1 -> count 0, `empty`=1, no error; with `SYNC_FIFO_FWFT_EN`, write 0x5A -> `data_out`=0x5A one cycle later without `read_en`.
